// File: rtl/stream_serializer.sv
// Parallel-load, LSB-first serializer feeding a downstream bit-serial FSM.
// Define SERIALIZER_LOOP_EN to repeat the captured pattern until abort/RESET.
module stream_serializer #(
    parameter int WIDTH = 20
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             load_ready,
    input  logic             hold,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic [4:0]       bit_count,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic             r_x;
    logic             r_x_valid;
    logic [4:0]       r_bit_count;
    logic             r_done;
    logic             r_load_ready;
    logic             w_last;

    assign w_last     = (r_bit_count == 5'(WIDTH - 1));
    assign x          = r_x;
    assign x_valid    = r_x_valid;
    assign bit_count  = r_bit_count;
    assign done       = r_done;
    assign load_ready = r_load_ready;

    // r_shift is a rotator: r_shift[0] is always the next bit to emit, and
    // after WIDTH rotations it holds the original pattern again for looping.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_x          <= 1'b0;
            r_x_valid    <= 1'b0;
            r_bit_count  <= 5'd0;
            r_done       <= 1'b0;
            r_load_ready <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load_valid) begin
                        r_state      <= SHIFT;
                        r_shift      <= {data_in[0], data_in[WIDTH-1:1]};
                        r_x          <= data_in[0];
                        r_x_valid    <= 1'b1;
                        r_bit_count  <= 5'd0;
                        r_load_ready <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        r_state      <= IDLE;
                        r_x          <= 1'b0;
                        r_x_valid    <= 1'b0;
                        r_bit_count  <= 5'd0;
                        r_load_ready <= 1'b1;
                    end else if (!hold) begin
                        if (w_last) begin
`ifdef SERIALIZER_LOOP_EN
                            r_x         <= r_shift[0];
                            r_shift     <= {r_shift[0], r_shift[WIDTH-1:1]};
                            r_bit_count <= 5'd0;
                            r_done      <= 1'b1;
`else
                            r_state     <= DONE;
                            r_x         <= 1'b0;
                            r_x_valid   <= 1'b0;
                            r_bit_count <= 5'd0;
                            r_done      <= 1'b1;
`endif
                        end else begin
                            r_x         <= r_shift[0];
                            r_shift     <= {r_shift[0], r_shift[WIDTH-1:1]};
                            r_bit_count <= r_bit_count + 5'd1;
                        end
                    end
                end
                DONE: begin
                    // abort here lands in the same place as normal exit
                    r_state      <= IDLE;
                    r_x          <= 1'b0;
                    r_x_valid    <= 1'b0;
                    r_bit_count  <= 5'd0;
                    r_load_ready <= 1'b1;
                end
                default: begin
                    r_state      <= IDLE;
                    r_x          <= 1'b0;
                    r_x_valid    <= 1'b0;
                    r_bit_count  <= 5'd0;
                    r_load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_serializer.sv
// Scoreboard bench for stream_serializer: stimulus queues expected output
// cycles, a negedge monitor pops one entry per cycle with x_valid or done.
module tb_stream_serializer;

    localparam int W = 20;
    localparam logic [W-1:0] PAT = 20'b10000111010011011011;
    // Emission order of PAT written out by hand: EXP[i] is the bit after E0+i.
    localparam logic [0:W-1] EXP = 20'b11011011001011100001;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         load_valid;
    logic [W-1:0] data_in;
    logic         load_ready;
    logic         hold;
    logic         abort;
    logic         x;
    logic         x_valid;
    logic [4:0]   bit_count;
    logic         done;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] q[$];
    logic [7:0] m_exp;

    stream_serializer #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET), .load_valid(load_valid), .data_in(data_in),
        .load_ready(load_ready), .hold(hold), .abort(abort), .x(x),
        .x_valid(x_valid), .bit_count(bit_count), .done(done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Queue entries are {x_valid, x, done, bit_count}.
    task automatic push_bit(input logic b, input int i);
        q.push_back({1'b1, b, 1'b0, 5'(i)});
    endtask

    task automatic push_done();
        q.push_back(8'b0_0_1_00000);
    endtask

    task automatic chk_idle(input string name);
        check(name, {load_ready, x_valid, x, done, bit_count}, {1'b1, 1'b0, 1'b0, 1'b0, 5'd0});
    endtask

    task automatic chk_drain(input string name);
        check(name, q.size(), 0);
        q.delete();
    endtask

    always @(negedge CLK) begin
        if (x_valid === 1'b1 || done === 1'b1) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got %0h expected no output at %0t",
                         {x_valid, x, done, bit_count}, $time);
            end else begin
                m_exp = q.pop_front();
                check("stream", {x_valid, x, done, bit_count}, m_exp);
            end
        end
    end

    initial begin
        // Reset must override a concurrent load, hold and abort.
        RESET = 1'b1; load_valid = 1'b1; hold = 1'b1; abort = 1'b1; data_in = PAT;
        tick(); tick();
        chk_idle("reset_state");

        // First load on the first edge after RESET drops.
        RESET = 1'b0; hold = 1'b0; abort = 1'b0; load_valid = 1'b1; data_in = PAT;
        for (int i = 0; i < W; i++) push_bit(EXP[i], i);
`ifdef SERIALIZER_LOOP_EN
        q.push_back({1'b1, EXP[0], 1'b1, 5'd0});
        for (int i = 1; i < W; i++) push_bit(EXP[i], i);
        tick();                                  // E0
        load_valid = 1'b0;
        check("load_ready_in_shift", load_ready, 1'b0);
        repeat (39) tick();                      // E0+39: second pass bit 19
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("loop_abort");
        chk_drain("loop_drain");
`else
        push_done();
        tick();                                  // E0
        load_valid = 1'b0;
        check("load_ready_in_shift", load_ready, 1'b0);
        // Loads offered mid-pattern with different data must be ignored.
        for (int t = 1; t <= 20; t++) begin
            load_valid = (t >= 5 && t <= 8);
            data_in    = load_valid ? ~PAT : PAT;
            tick();
        end
        // Load offered while in DONE is ignored too.
        load_valid = 1'b1; data_in = ~PAT;
        tick();                                  // E0+21
        load_valid = 1'b0;
        chk_idle("idle_after_done");
        chk_drain("basic_drain");

        // Hold during handshake is ignored; hold over three edges with bit 4 on x.
        data_in = PAT; load_valid = 1'b1; hold = 1'b1;
        for (int i = 0; i <= 4; i++) push_bit(EXP[i], i);
        repeat (3) push_bit(EXP[4], 4);
        for (int i = 5; i < W; i++) push_bit(EXP[i], i);
        push_done();
        tick();                                  // E0
        load_valid = 1'b0; hold = 1'b0;
        repeat (4) tick();                       // E0+4
        hold = 1'b1;
        repeat (3) tick();                       // E0+5..E0+7
        hold = 1'b0;
        repeat (16) tick();                      // E0+23 is the done cycle
        tick();
        chk_idle("idle_after_hold");
        chk_drain("hold_drain");

        // RESET mid-pattern discards it without a done pulse.
        data_in = PAT; load_valid = 1'b1;
        for (int i = 0; i <= 12; i++) push_bit(EXP[i], i);
        tick();                                  // E0
        load_valid = 1'b0;
        repeat (12) tick();                      // E0+12
        RESET = 1'b1;
        tick();                                  // E0+13
        chk_idle("mid_reset");
        chk_drain("mid_reset_drain");
        RESET = 1'b0; load_valid = 1'b1; data_in = 20'h00001;
        for (int i = 0; i < W; i++) push_bit(i == 0, i);
        push_done();
        tick();
        load_valid = 1'b0;
        repeat (20) tick();
        tick();
        chk_idle("idle_after_reload");
        chk_drain("reload_drain");

        // Abort wins over hold at E0+7.
        data_in = PAT; load_valid = 1'b1;
        for (int i = 0; i <= 6; i++) push_bit(EXP[i], i);
        tick();                                  // E0
        load_valid = 1'b0;
        repeat (6) tick();                       // E0+6
        hold = 1'b1; abort = 1'b1;
        tick();                                  // E0+7
        hold = 1'b0;
        chk_idle("abort_with_hold");
        chk_drain("abort_drain");
        // Abort with load in IDLE still performs the handshake.
        load_valid = 1'b1; data_in = 20'hFFFFE;
        for (int i = 0; i < W; i++) push_bit(i != 0, i);
        push_done();
        tick();
        abort = 1'b0; load_valid = 1'b0;
        repeat (20) tick();
        tick();
        chk_idle("idle_after_abort_load");
        chk_drain("abort_load_drain");
`endif
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
